// File: rtl/forth_pkg.sv
// Shared definitions for the Forth stack controllers: state encoding and default widths.
package forth_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic {
    IDLE     = 1'b0,
    POP_WAIT = 1'b1
  } stack_state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller: top entry held in a register, the rest spilled to an external
// simple dual-port RAM with registered read data.
//
// state    | meaning
// IDLE     | accepting push/pop requests
// POP_WAIT | refill of tos from RAM in flight, requests ignored
module stack_ctrl
  import forth_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] tos,
  output logic                  tos_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0] DEPTH_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_TWO = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] DEPTH_MAX = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) + 1);

  stack_state_t          state_q;
  logic [ADDR_WIDTH:0]   depth_q;
  logic [DATA_WIDTH-1:0] tos_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  idle;
  logic                  push_only;
  logic                  pop_only;
  logic                  pop_refill;
  logic                  set_ovf;
  logic                  set_udf;
  logic [ADDR_WIDTH-1:0] sp;
  logic [ADDR_WIDTH-1:0] sp_dec;

  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DEPTH_MAX);
  assign tos_valid = !empty;
  assign depth     = depth_q;
  assign tos       = tos_q;
  assign busy      = (state_q == POP_WAIT);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // sp = depth-1; the low address bits alone suffice because a full stack
  // (depth 2**ADDR_WIDTH+1) never addresses RAM.
  assign sp     = empty ? '0 : depth_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign sp_dec = sp - ADDR_WIDTH'(1);

  assign idle       = (state_q == IDLE) && !reset;
  assign push_only  = idle && push && !pop;
  assign pop_only   = idle && pop && !push;
  assign pop_refill = pop_only && (depth_q >= DEPTH_TWO);
  assign set_ovf    = push_only && full;
  assign set_udf    = idle && pop && empty;

  assign ram_we         = push_only && !full && !empty;
  assign ram_write_addr = sp;
  assign ram_data       = tos_q;
  assign ram_read_addr  = pop_refill ? sp_dec : sp;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      tos_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= set_ovf || (overflow_q && !clear_err);
      underflow_q <= set_udf || (underflow_q && !clear_err);
      case (state_q)
        IDLE: begin
          if (push && pop) begin
            tos_q <= push_data;
            if (empty) depth_q <= DEPTH_ONE;
          end else if (push) begin
            if (!full) begin
              tos_q   <= push_data;
              depth_q <= depth_q + DEPTH_ONE;
            end
          end else if (pop) begin
            if (!empty) begin
              depth_q <= depth_q - DEPTH_ONE;
              if (depth_q >= DEPTH_TWO) state_q <= POP_WAIT;
            end
          end
        end
        POP_WAIT: begin
          tos_q   <= ram_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: queue-based stack model, bench-side RAM, directed and random stimulus.
module tb_stack_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int MAXD = (1 << AW) + 1;
  localparam int AMASK = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] tos;
  logic          tos_valid;
  logic          busy;
  logic [AW:0]   depth;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_write_addr;
  logic [AW-1:0] ram_read_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
    .clear_err(clear_err), .tos(tos), .tos_valid(tos_valid), .busy(busy),
    .depth(depth), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .ram_data(ram_data), .ram_write_addr(ram_write_addr),
    .ram_read_addr(ram_read_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  // Model: whole stack as a queue, top at the back.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] tos_m = '0;
  logic          busy_m = 1'b0;
  logic          ovf_m = 1'b0;
  logic          udf_m = 1'b0;
  logic          model_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  int last_raddr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [DW-1:0] d,
                      input logic c, input logic r);
    int n;
    logic exp_we, set_o, set_u;
    int exp_ra;
    push = p; pop = q; push_data = d; clear_err = c; reset = r;
    #1;
    n = stk.size();
    if (model_valid) begin
      chk("depth", int'(depth), n);
      chk("tos_valid", int'(tos_valid), int'(n != 0));
      chk("empty", int'(empty), int'(n == 0));
      chk("full", int'(full), int'(n == MAXD));
      chk("busy", int'(busy), int'(busy_m));
      chk("overflow", int'(overflow), int'(ovf_m));
      chk("underflow", int'(underflow), int'(udf_m));
      chk("tos", int'(tos), int'(tos_m));
      exp_we = !r && !busy_m && p && !q && n >= 1 && n < MAXD;
      chk("ram_we", int'(ram_we), int'(exp_we));
      if (exp_we) begin
        chk("ram_write_addr", int'(ram_write_addr), n - 1);
        chk("ram_data", int'(ram_data), int'(stk[n-1]));
      end
      if (!r && !busy_m && q && !p && n >= 2) exp_ra = n - 2;
      else exp_ra = (n == 0) ? 0 : n - 1;
      chk("ram_read_addr", int'(ram_read_addr), exp_ra & AMASK);
    end
    last_raddr = int'(ram_read_addr);
    if (ram_we) we_count++;
    @(posedge clock);
    if (r) begin
      stk.delete();
      tos_m = '0; busy_m = 1'b0; ovf_m = 1'b0; udf_m = 1'b0;
      model_valid = 1'b1;
    end else begin
      set_o = !busy_m && p && !q && n == MAXD;
      set_u = !busy_m && q && n == 0;
      if (busy_m) begin
        tos_m = stk[n-1];
        busy_m = 1'b0;
      end else if (p && q) begin
        if (n == 0) stk.push_back(d);
        else stk[n-1] = d;
        tos_m = d;
      end else if (p) begin
        if (n < MAXD) begin
          stk.push_back(d);
          tos_m = d;
        end
      end else if (q) begin
        if (n >= 2) busy_m = 1'b1;
        if (n >= 1) void'(stk.pop_back());
      end
      ovf_m = set_o || (ovf_m && !c);
      udf_m = set_u || (udf_m && !c);
    end
    @(negedge clock);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int bias, we0;
    @(negedge clock);
    step(0, 0, '0, 0, 1);
    step(1, 1, 16'h1234, 1, 1);
    chk("lit_rst_depth", int'(depth), 0);
    chk("lit_rst_busy", int'(busy), 0);

    // Three pushes: two spills to RAM
    we_count = 0;
    step(1, 0, 16'h0001, 0, 0);
    step(1, 0, 16'h0002, 0, 0);
    step(1, 0, 16'h0003, 0, 0);
    chk("lit_push3_depth", int'(depth), 3);
    chk("lit_push3_tos", int'(tos), 16'h0003);
    chk("lit_ram0", int'(mem[0]), 16'h0001);
    chk("lit_ram1", int'(mem[1]), 16'h0002);
    chk("lit_we_count", we_count, 2);

    // Pop with refill, push ignored while busy
    step(0, 1, '0, 0, 0);
    chk("lit_pop_raddr", last_raddr, 1);
    chk("lit_pop_busy", int'(busy), 1);
    step(1, 0, 16'h0077, 0, 0);
    chk("lit_pop_tos", int'(tos), 16'h0002);
    chk("lit_pop_depth", int'(depth), 2);
    chk("lit_busy_push_ignored", int'(mem[1]), 16'h0002);
    step(0, 1, '0, 0, 0);
    idle_step();
    chk("lit_pop2_tos", int'(tos), 16'h0001);
    step(0, 1, '0, 0, 0);
    chk("lit_pop3_valid", int'(tos_valid), 0);
    chk("lit_pop3_tos_hold", int'(tos), 16'h0001);

    // Underflow, clear, push+pop on empty
    step(0, 1, '0, 0, 0);
    chk("lit_udf", int'(underflow), 1);
    step(0, 0, '0, 1, 0);
    chk("lit_udf_clr", int'(underflow), 0);
    step(1, 1, 16'h0055, 0, 0);
    chk("lit_pp_empty_tos", int'(tos), 16'h0055);
    chk("lit_pp_empty_depth", int'(depth), 1);
    chk("lit_pp_empty_udf", int'(underflow), 1);

    // Reset during refill aborts it
    step(1, 0, 16'h000A, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    chk("lit_rst_pw_busy", int'(busy), 0);
    chk("lit_rst_pw_tos", int'(tos), 0);
    idle_step();
    chk("lit_rst_pw_tos_after", int'(tos), 0);

    // Fill to capacity
    for (int i = 0; i < MAXD; i++) step(1, 0, 16'($urandom), 0, 0);
    chk("lit_full", int'(full), 1);
    chk("lit_full_depth", int'(depth), MAXD);
    step(1, 0, 16'h1111, 0, 0);
    chk("lit_ovf", int'(overflow), 1);
    chk("lit_ovf_depth", int'(depth), MAXD);
    we0 = we_count;
    step(1, 1, 16'hBEEF, 0, 0);
    chk("lit_replace_tos", int'(tos), 16'hBEEF);
    chk("lit_replace_depth", int'(depth), MAXD);
    chk("lit_replace_no_we", we_count, we0);
    for (int i = 0; i < 6; i++) step(0, 1, '0, 0, 0);

    // Random phase with alternating push/pop bias
    bias = 70;
    for (int i = 0; i < 6000; i++) begin
      if (i % 700 == 0) bias = (bias == 70) ? 30 : 70;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
           16'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning stack word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning RAM address width; RAM backing capacity is 2**ADDR_WIDTH words.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port push  input  1  push request.
REQ-006 SHALL have port pop  input  1  pop request.
REQ-007 SHALL have port push_data  input  DATA_WIDTH  word to push.
REQ-008 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-009 SHALL have port tos  output  DATA_WIDTH  registered top-of-stack word.
REQ-010 SHALL have port tos_valid  output  1  high when depth >= 1.
REQ-011 SHALL have port busy  output  1  high while a pop refill is in flight.
REQ-012 SHALL have port depth  output  ADDR_WIDTH+1  entries held, TOS register included.
REQ-013 SHALL have ports empty, full  output  1 each  depth == 0, depth == 2**ADDR_WIDTH + 1.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-015 SHALL have ports ram_data (DATA_WIDTH), ram_write_addr, ram_read_addr (ADDR_WIDTH), ram_we (1)  outputs  to external simple dual-port RAM.
REQ-016 SHALL have port ram_q  input  DATA_WIDTH  RAM registered read data, valid one cycle after ram_read_addr is sampled.

Function
REQ-017 SHALL keep the top entry in the tos register and entries below it in RAM at addresses 0..sp-1, with sp = depth-1 when non-empty, sp = 0 when empty.
REQ-018 SHALL implement states IDLE and POP_WAIT; busy = 1 exactly in POP_WAIT.
REQ-019 SHALL ignore push/pop while busy, with no flag change; requesters hold the request until busy is low.
REQ-020 On push alone in IDLE, not full, non-empty: ram_we=1, ram_write_addr=sp, ram_data=tos, sp+1, tos<=push_data, depth+1; new tos is visible the next cycle.
REQ-021 On push alone in IDLE when empty: no RAM write, tos<=push_data, tos_valid<=1, depth<=1.
REQ-022 On push alone when full: push is dropped, state is unchanged, overflow<=1.
REQ-023 On pop alone in IDLE with depth >= 2: ram_read_addr=sp-1 the same cycle, sp-1, depth-1, go to POP_WAIT; in POP_WAIT tos<=ram_q, return to IDLE; new tos is visible 2 cycles after the request.
REQ-024 On pop alone with depth == 1: no RAM access, depth<=0, tos_valid<=0, tos holds its old value, stays IDLE.
REQ-025 On pop alone when empty: pop is dropped, underflow<=1.
REQ-026 On push and pop in the same IDLE cycle with depth >= 1: replace, meaning tos<=push_data, with depth, sp and RAM untouched, including when full.
REQ-027 On push and pop in the same IDLE cycle when empty: the push is performed per REQ-021 and underflow<=1.
REQ-028 SHALL assert ram_we only in the REQ-020 case, and for exactly one cycle.
REQ-029 SHALL hold ram_read_addr at sp-1 when a pop is accepted and at sp otherwise; sp never wraps.
REQ-030 On clear_err: overflow<=0 and underflow<=0 the next cycle; an error event in the same cycle wins and sets the flag.
REQ-031 SHALL derive empty, full and tos_valid combinationally from depth.

Reset
REQ-032 On reset: state IDLE, sp 0, depth 0, tos 0, tos_valid 0, overflow 0, underflow 0, ram_we 0, busy 0; RAM contents are not cleared.
REQ-033 Reset asserted in POP_WAIT SHALL abort the refill; the late ram_q is discarded.
REQ-034 Reset SHALL dominate push, pop and clear_err in the same cycle.

Structure
REQ-035 SHALL place the state encoding (IDLE, POP_WAIT) and default width constants in shared package forth_pkg.
REQ-036 SHALL leave the RAM external; the integration top pairs stack_ctrl with the team's dual-port RAM, one instance per Forth stack (data and return).
REQ-037 SHALL have no sub-module; the logic is one FSM plus pointer/depth counters.

Verification
REQ-038 Reset, push 0x0001, 0x0002, 0x0003 -> depth 3, tos 0x0003, RAM[0]=0x0001, RAM[1]=0x0002, ram_we pulsed twice.
REQ-039 From REQ-038 state, pop -> busy 1 for one cycle, ram_read_addr 1, tos 0x0002 two cycles after the request, depth 2; two more pops -> tos 0x0001, then empty with tos_valid 0.
REQ-040 Pop when empty -> underflow 1, depth 0; clear_err -> underflow 0 next cycle; push plus pop when empty -> tos=push_data, depth 1, underflow 1.
REQ-041 Push 1025 words (ADDR_WIDTH=10) -> full 1, depth 1025; a further push -> dropped, overflow 1; push+pop with 0xBEEF -> tos 0xBEEF, depth 1025, no ram_we.
REQ-042 Push during POP_WAIT -> ignored, depth and RAM unchanged; reset asserted in POP_WAIT -> all outputs per REQ-032 next cycle.
